// File: rtl/circuit2_seq_pkg.sv
// Shared types for the circuit2 sequencer: FSM states, ALU op codes
// and the default operand width used by the controller and its ALU.
package circuit2_seq_pkg;

    localparam int DEF_DATAWIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        SD,
        SE,
        SF,
        SCMP,
        SOUT
    } state_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/seq_alu.sv
// Shared combinational add/sub unit, time-multiplexed by the controller.
// Ports: op (ALU_ADD/ALU_SUB), a, b operands; y = a+b or a-b, carry dropped.
module seq_alu
    import circuit2_seq_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 op,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] y
);

    always_comb begin
        y = a + b;
        if (op == ALU_SUB) begin
            y = a - b;
        end
    end

endmodule

// File: rtl/circuit2_seq_ctrl.sv
// Multi-cycle sequencer computing x,z from a,b,c with one shared ALU.
// Ports: Clk, Rst (async low), start, a, b, c in; busy, done, x, z out.
module circuit2_seq_ctrl
    import circuit2_seq_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] x,
    output logic [DATAWIDTH-1:0] z
);

    state_t state;
    state_t state_nxt;

    logic [DATAWIDTH-1:0] ra;
    logic [DATAWIDTH-1:0] rb;
    logic [DATAWIDTH-1:0] rc;
    logic [DATAWIDTH-1:0] d_r;
    logic [DATAWIDTH-1:0] e_r;
    logic [DATAWIDTH-1:0] f_r;
    logic                 lt_r;
    logic                 eq_r;

    logic                 alu_op;
    logic [DATAWIDTH-1:0] alu_b;
    logic [DATAWIDTH-1:0] alu_y;

    logic [DATAWIDTH-1:0] g;
    logic [DATAWIDTH-1:0] h;
    logic [DATAWIDTH-1:0] x_nxt;
    logic [DATAWIDTH-1:0] z_nxt;

    seq_alu #(
        .DATAWIDTH(DATAWIDTH)
    ) u_alu (
        .op(alu_op),
        .a (ra),
        .b (alu_b),
        .y (alu_y)
    );

    // Next state and ALU steering; operand a is always ra.
    always_comb begin
        state_nxt = state;
        alu_op    = ALU_ADD;
        alu_b     = rb;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SD;
                end
            end
            SD: begin
                state_nxt = SE;
            end
            SE: begin
                alu_b     = rc;
                state_nxt = SF;
            end
            SF: begin
                alu_op    = ALU_SUB;
                state_nxt = SCMP;
            end
            SCMP: begin
                state_nxt = SOUT;
            end
            SOUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Select and shift stage, consumed only in SOUT.
    always_comb begin
        g     = lt_r ? e_r : d_r;
        h     = eq_r ? f_r : g;
        x_nxt = g << lt_r;
        z_nxt = h >> eq_r;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            x     <= '0;
            z     <= '0;
            ra    <= '0;
            rb    <= '0;
            rc    <= '0;
            d_r   <= '0;
            e_r   <= '0;
            f_r   <= '0;
            lt_r  <= 1'b0;
            eq_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state == SOUT);
            if (state == IDLE && start) begin
                ra <= a;
                rb <= b;
                rc <= c;
            end
            if (state == SD) begin
                d_r <= alu_y;
            end
            if (state == SE) begin
                e_r <= alu_y;
            end
            if (state == SF) begin
                f_r <= alu_y;
            end
            if (state == SCMP) begin
                lt_r <= (d_r < e_r);
                eq_r <= (d_r == e_r);
            end
            if (state == SOUT) begin
                x <= x_nxt;
                z <= z_nxt;
            end
        end
    end

endmodule

// File: doc/circuit2_seq_ctrl.md
Name: circuit2_seq_ctrl

Overview:
- Multi-cycle sequencer that computes the two-output compare/select/shift function x,z from operands a,b,c.
- Uses one shared adder/subtractor and one comparator, time-multiplexed across cycles, instead of three parallel arithmetic units.
- Sits where the fully parallel datapath would sit.
- Trades latency for area, with a start/busy/done handshake toward the requester.

Parameters:
DATAWIDTH, 32, width of a, b, c, x, z and all internal operand/result registers

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when state is IDLE
a  input  DATAWIDTH  operand, captured on the accepted start
b  input  DATAWIDTH  operand, captured on the accepted start
c  input  DATAWIDTH  operand, captured on the accepted start
busy  output  1  high while a computation is in flight
done  output  1  one-cycle pulse; x,z are valid from this cycle on
x  output  DATAWIDTH  registered result x
z  output  DATAWIDTH  registered result z

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE; busy=0, done=0, x=0, z=0; all internal registers cleared.
- Function (all arithmetic unsigned, modulo 2^DATAWIDTH):
  - d=a+b, e=a+c, f=a-b
  - lt=(d<e), eq=(d==e)
  - g = lt ? e : d
  - h = eq ? f : g
  - x = g << lt (shift by 0 or 1, zero fill)
  - z = h >> eq (logical shift, zero fill)
- FSM states: IDLE, SD, SE, SF, SCMP, SOUT.
- Transitions:
  - IDLE: start=1 captures a,b,c into ra,rb,rc, then go to SD. Otherwise stay in IDLE.
  - SD: shared ALU ADD ra,rb; result into d_r. Go to SE.
  - SE: ALU ADD ra,rc; result into e_r. Go to SF.
  - SF: ALU SUB ra,rb; result into f_r. Go to SCMP.
  - SCMP: compare d_r with e_r; register lt_r, eq_r. Go to SOUT.
  - SOUT: form g, h and the shifts combinationally; register x,z; set done=1. Go to IDLE.
- Timing: start accepted at edge 0; done=1 and new x,z visible in the cycle after edge 5.
- busy = (state != IDLE), registered.
- done is high exactly one cycle and is otherwise 0.
- x,z hold their value until the next SOUT.
- start while busy is ignored; it is not queued.
- In the done cycle the state is IDLE, so start is accepted. Back-to-back throughput is one result per 6 cycles.
- a,b,c may change freely after the accepting edge; only the captured copies are used.
- Reset mid-operation aborts the computation: no done pulse, and outputs return to reset values immediately.
- Carry and borrow are discarded. No overflow flag.

Decomposition:
- Package circuit2_seq_pkg:
  - state enum (IDLE, SD, SE, SF, SCMP, SOUT)
  - ALU op constants (ALU_ADD, ALU_SUB)
  - default DATAWIDTH
- Sub-module seq_alu: combinational, DATAWIDTH-parameterized add/sub with op select. It is the single shared arithmetic unit.
- The comparator, muxes and shifters stay inline in the controller.

Test Plan:
- a=5,b=3,c=1, start one cycle:
  - busy=1 for 5 cycles, then done=1 for one cycle
  - d=8, e=6, f=2, lt=0, eq=0 -> x=8, z=8
- a=1,b=2,c=4:
  - d=3, e=5, f=0xFFFFFFFF, lt=1 -> g=5, h=5 -> x=10, z=5
- a=4,b=2,c=2:
  - d=e=6, eq=1, h=f=2 -> x=6, z=1
- Wrap case a=0xFFFFFFFF,b=1,c=2:
  - d=0, e=1, lt=1 -> x=2, z=1
  - also check f=0xFFFFFFFE internally
- Handshake:
  - Pulse start again on cycle 2 with a=9: ignored; result is from the original operands.
  - Start on the done cycle with a=1,b=2,c=4: accepted, and a second done arrives exactly 6 cycles later with x=10, z=5.
- Reset abort: drive Rst=0 during SF -> x=z=0, busy=0, and no done pulse. After release, a normal start gives the correct result with 6-cycle latency.
